// File: rtl/pc_control_if.sv
// pc_control_if: groups the sequencing-side signals of pc_control.
//   master modport (driver of control/instruction fields, consumer of PC state):
//     drives  PCSour, HLT, cond, imm, rs_data, flag_we, alu_flags
//     reads   pc, pc_plus2, taken, flags, halted
//   slave modport (pc_control itself) is the mirror image.
// Handshake: there is no valid/ready pair here; every input is treated as
// valid on every rising clk edge, and the outputs are always meaningful.
interface pc_control_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       PCSour;
  logic             HLT;
  logic [2:0]       cond;
  logic [8:0]       imm;
  logic [WIDTH-1:0] rs_data;
  logic [2:0]       flag_we;
  logic [2:0]       alu_flags;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus2;
  logic             taken;
  logic [2:0]       flags;
  logic             halted;

  modport master (
    output PCSour, HLT, cond, imm, rs_data, flag_we, alu_flags,
    input  pc, pc_plus2, taken, flags, halted
  );

  modport slave (
    input  PCSour, HLT, cond, imm, rs_data, flag_we, alu_flags,
    output pc, pc_plus2, taken, flags, halted
  );
endinterface

// File: rtl/pc_control.sv
// pc_control: program counter, {Z,V,N} flag register and sticky halt state.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (pc=RESET_PC, flags=0, halted=0)
//   bus  : pc_control_if.slave
//     PCSour  00/10 = pc+2, 01 = register target, 11 = pc-relative immediate
//     HLT     enter HALT (pc holds, flag writes still land on that edge)
//     cond    branch condition, tested against the registered flags
//     imm     signed word offset for PCSour=11
//     rs_data register target for PCSour=01 (used unmodified)
//     flag_we / alu_flags  per-bit flag load
//     pc, pc_plus2, taken, flags, halted  outputs
// The two-state FSM is visible directly on bus.halted (HALT <=> halted=1).
module pc_control #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst,
  pc_control_if.slave bus
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;
  logic             cond_true;
  logic             taken;
  logic [WIDTH-1:0] pc_plus2;
  logic [WIDTH-1:0] br_off;

  // Flag bit positions within {Z,V,N}.
  logic flag_z, flag_v, flag_n;
  assign flag_z = flags_q[2];
  assign flag_v = flags_q[1];
  assign flag_n = flags_q[0];

  assign pc_plus2 = pc_q + TWO;
  // Word offset -> byte offset: sign-extend then shift left by one.
  assign br_off   = {{(WIDTH-10){bus.imm[8]}}, bus.imm, 1'b0};

  always_comb begin
    cond_true = 1'b0;
    case (bus.cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || (!flag_z && !flag_n);
      3'b101: cond_true = flag_n || flag_z;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  // PCSour bit0 distinguishes the two branch encodings (01, 11) from 00/10.
  assign taken = (state_q == RUN) && bus.PCSour[0] && cond_true;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    if (state_q == RUN) begin
      for (int i = 0; i < 3; i++) begin
        if (bus.flag_we[i]) flags_d[i] = bus.alu_flags[i];
      end
      if (bus.HLT) begin
        state_d = HALT;
      end else if (taken) begin
        pc_d = bus.PCSour[1] ? (pc_plus2 + br_off) : bus.rs_data;
      end else begin
        pc_d = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus2 = pc_plus2;
  assign bus.taken    = taken;
  assign bus.flags    = flags_q;
  assign bus.halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_control.sv
module tb_pc_control;

  logic clk;
  logic rst;

  pc_control_if #(.WIDTH(16)) bus ();

  pc_control #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_pc;
  bit   m_z, m_v, m_n;
  bit   m_halted;
  bit   m_valid;
  logic [19:0] exp_q[$];

  function automatic bit m_cond(input int c);
    case (c)
      0: return !m_z;
      1: return m_z;
      2: return !m_z && !m_n;
      3: return m_n;
      4: return m_z || (!m_z && !m_n);
      5: return m_n || m_z;
      6: return m_v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_taken();
    int ps;
    ps = int'(bus.PCSour);
    if (m_halted) return 1'b0;
    if (ps != 1 && ps != 3) return 1'b0;
    return m_cond(int'(bus.cond));
  endfunction

  always @(posedge clk) begin
    int off;
    bit tk;
    if (rst) begin
      m_pc = 0; m_z = 0; m_v = 0; m_n = 0; m_halted = 0; m_valid = 1;
    end else if (m_valid && !m_halted) begin
      tk  = m_taken();
      off = bus.imm[8] ? int'(bus.imm) - 512 : int'(bus.imm);
      if (bus.flag_we[2]) m_z = bus.alu_flags[2];
      if (bus.flag_we[1]) m_v = bus.alu_flags[1];
      if (bus.flag_we[0]) m_n = bus.alu_flags[0];
      if (bus.HLT) m_halted = 1;
      else if (tk && bus.PCSour == 2'b11) m_pc = (m_pc + 2 + off * 2) & 16'hFFFF;
      else if (tk) m_pc = int'(bus.rs_data);
      else m_pc = (m_pc + 2) & 16'hFFFF;
    end
    if (m_valid) exp_q.push_back({m_halted, m_z, m_v, m_n, m_pc[15:0]});
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [19:0] e;
    if (m_valid) begin
      chk("pc_plus2", bus.pc_plus2, (m_pc + 2) & 16'hFFFF);
      chk("taken", bus.taken, m_taken());
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pc", bus.pc, e[15:0]);
        chk("flags", bus.flags, e[18:16]);
        chk("halted", bus.halted, e[19]);
      end
    end
  end

  // ---------------- driver ----------------
  logic t_seen;

  task automatic apply(input logic r, input logic h, input logic [1:0] ps,
                       input logic [2:0] c, input logic [8:0] im,
                       input logic [15:0] rs, input logic [2:0] we,
                       input logic [2:0] af);
    rst = r; bus.HLT = h; bus.PCSour = ps; bus.cond = c; bus.imm = im;
    bus.rs_data = rs; bus.flag_we = we; bus.alu_flags = af;
    @(negedge clk);
    t_seen = bus.taken;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    n_vec = 0; n_err = 0; m_valid = 0;
    rst = 1'b1; bus.HLT = 0; bus.PCSour = 0; bus.cond = 0; bus.imm = 0;
    bus.rs_data = 0; bus.flag_we = 0; bus.alu_flags = 0;

    // Reset then sequential fetch.
    apply(1, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("reset_pc", bus.pc, 16'h0000);
    chk("reset_flags", bus.flags, 3'b000);
    chk("reset_halted", bus.halted, 1'b0);
    for (int i = 0; i < 4; i++) apply(0, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("seq_pc", bus.pc, 16'h0008);

    // B forward/backward from 0010 with Z=1.
    apply(0, 0, 2'b01, 3'b111, 0, 16'h0010, 3'b100, 3'b100);
    chk("br_0010", bus.pc, 16'h0010);
    chk("z_set", bus.flags, 3'b100);
    apply(0, 0, 2'b11, 3'b001, 9'h003, 0, 0, 0);
    chk("b_eq_taken", t_seen, 1'b1);
    chk("b_fwd_pc", bus.pc, 16'h0018);
    apply(0, 0, 2'b11, 3'b111, 9'h1FC, 0, 0, 0);
    chk("b_back_pc", bus.pc, 16'h0012);

    // Not taken, flag write in the same cycle seen one cycle later.
    apply(0, 0, 2'b00, 0, 0, 0, 3'b111, 3'b000);
    apply(0, 0, 2'b11, 3'b011, 9'h010, 0, 3'b001, 3'b001);
    chk("lt_not_taken", t_seen, 1'b0);
    chk("lt_nt_pc", bus.pc, 16'h0016);
    chk("n_set", bus.flags, 3'b001);
    apply(0, 0, 2'b11, 3'b011, 9'h000, 0, 0, 0);
    chk("lt_taken", t_seen, 1'b1);
    chk("lt_t_pc", bus.pc, 16'h0018);

    // BR and wrap-around.
    apply(0, 0, 2'b01, 3'b111, 0, 16'h1234, 0, 0);
    chk("br_1234", bus.pc, 16'h1234);
    apply(0, 0, 2'b01, 3'b111, 0, 16'hFFFE, 0, 0);
    apply(0, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("wrap_pc", bus.pc, 16'h0000);

    // Halt: pc holds, flag write on the HLT edge still lands.
    apply(0, 0, 2'b01, 3'b111, 0, 16'h0020, 0, 0);
    apply(0, 1, 2'b00, 0, 0, 0, 3'b010, 3'b010);
    chk("halt_pc", bus.pc, 16'h0020);
    chk("halt_flag", bus.halted, 1'b1);
    chk("halt_flags", bus.flags, 3'b011);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 2'b11, 3'b111, 9'h0AA, 16'h5555, 3'b111, 3'($urandom_range(0, 7)));
      chk("halted_taken", t_seen, 1'b0);
    end
    chk("halted_pc", bus.pc, 16'h0020);
    chk("halted_flags", bus.flags, 3'b011);
    apply(1, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("unhalt_pc", bus.pc, 16'h0000);
    chk("unhalt_halted", bus.halted, 1'b0);

    // Reset beats HLT, BR and flag writes on the same edge.
    apply(0, 0, 2'b00, 0, 0, 0, 3'b111, 3'b111);
    apply(1, 1, 2'b01, 3'b111, 0, 16'hABCD, 3'b111, 3'b111);
    chk("rprio_pc", bus.pc, 16'h0000);
    chk("rprio_halted", bus.halted, 1'b0);
    chk("rprio_flags", bus.flags, 3'b000);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            9'($urandom_range(0, 511)), 16'($urandom_range(0, 65535)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
